// File: rtl/watch_bcd_rtc.sv
// BCD real-time clock: 24h internal time with prescaler, run/pause, handshaked set, 12h display mapping and tick strobes.
// Optional alarm compare (alarm_hit) is built when ALARM_CMP_EN is defined.
module watch_bcd_rtc #(
  parameter int CLK_DIV = 100000000,
  parameter int RST_HD  = 0,
  parameter int RST_HO  = 0,
  parameter int RST_MD  = 0,
  parameter int RST_MO  = 0,
  localparam int CNT_W  = $clog2(CLK_DIV)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  input  logic       mode12,
  input  logic       set_valid,
  input  logic [3:0] set_hd,
  input  logic [3:0] set_ho,
  input  logic [3:0] set_md,
  input  logic [3:0] set_mo,
  input  logic [3:0] set_sd,
  input  logic [3:0] set_so,
  output logic       set_ack,
  output logic       set_err,
  output logic [3:0] hd_now,
  output logic [3:0] ho_now,
  output logic [3:0] md_now,
  output logic [3:0] mo_now,
  output logic [3:0] sd_now,
  output logic [3:0] so_now,
  output logic       pm,
  output logic       sec_tick,
`ifdef ALARM_CMP_EN
  input  logic [3:0] al_hd,
  input  logic [3:0] al_ho,
  input  logic [3:0] al_md,
  input  logic [3:0] al_mo,
  input  logic       al_en,
  output logic       alarm_hit,
`endif
  output logic       min_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] hd_q, hd_d, ho_q, ho_d, md_q, md_d, mo_q, mo_d, sd_q, sd_d, so_q, so_d;
  logic       ack_q, ack_d, err_q, err_d, sec_tick_q, sec_tick_d, min_tick_q, min_tick_d;
  logic       wrap, sec_wrap, min_wrap, set_ok;
`ifdef ALARM_CMP_EN
  logic       alarm_q, alarm_d;
`endif

  assign wrap     = run && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign sec_wrap = (sd_q == 4'd5) && (so_q == 4'd9);
  assign min_wrap = (md_q == 4'd5) && (mo_q == 4'd9);
  assign set_ok   = (set_hd <= 4'd2) && (set_ho <= 4'd9) &&
                    ((set_hd < 4'd2) || (set_ho <= 4'd3)) &&
                    (set_md <= 4'd5) && (set_mo <= 4'd9) &&
                    (set_sd <= 4'd5) && (set_so <= 4'd9);

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    cnt_d      = cnt_q;
    hd_d       = hd_q;
    ho_d       = ho_q;
    md_d       = md_q;
    mo_d       = mo_q;
    sd_d       = sd_q;
    so_d       = so_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
`ifdef ALARM_CMP_EN
    alarm_d    = 1'b0;
`endif
    // Any set request owns the cycle: a coinciding second advance is dropped.
    if (set_valid) begin
      if (set_ok) begin
        hd_d  = set_hd;
        ho_d  = set_ho;
        md_d  = set_md;
        mo_d  = set_mo;
        sd_d  = set_sd;
        so_d  = set_so;
        cnt_d = '0;
        ack_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (wrap) begin
      cnt_d      = '0;
      sec_tick_d = 1'b1;
      so_d       = (so_q == 4'd9) ? 4'd0 : so_q + 4'd1;
      if (so_q == 4'd9) sd_d = (sd_q == 4'd5) ? 4'd0 : sd_q + 4'd1;
      if (sec_wrap) begin
        min_tick_d = 1'b1;
        mo_d       = (mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
        if (mo_q == 4'd9) md_d = (md_q == 4'd5) ? 4'd0 : md_q + 4'd1;
        if (min_wrap) begin
          if (hd_q == 4'd2 && ho_q == 4'd3) begin
            hd_d = 4'd0;
            ho_d = 4'd0;
          end else if (ho_q == 4'd9) begin
            hd_d = hd_q + 4'd1;
            ho_d = 4'd0;
          end else begin
            ho_d = ho_q + 4'd1;
          end
        end
`ifdef ALARM_CMP_EN
        alarm_d = al_en && ({hd_d, ho_d, md_d, mo_d} == {al_hd, al_ho, al_md, al_mo});
`endif
      end
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      hd_q       <= 4'(RST_HD);
      ho_q       <= 4'(RST_HO);
      md_q       <= 4'(RST_MD);
      mo_q       <= 4'(RST_MO);
      sd_q       <= 4'd0;
      so_q       <= 4'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hd_q       <= hd_d;
      ho_q       <= ho_d;
      md_q       <= md_d;
      mo_q       <= mo_d;
      sd_q       <= sd_d;
      so_q       <= so_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
    end
  end

`ifdef ALARM_CMP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) alarm_q <= 1'b0;
    else       alarm_q <= alarm_d;
  end
  assign alarm_hit = alarm_q;
`endif

  // 12h display: 00 shows as 12, 13..23 fold down to 01..11; pm marks 12..23.
  always_comb begin
    hd_now = hd_q;
    ho_now = ho_q;
    pm     = 1'b0;
    if (mode12) begin
      if (hd_q == 4'd0) begin
        if (ho_q == 4'd0) begin
          hd_now = 4'd1;
          ho_now = 4'd2;
        end
      end else if (hd_q == 4'd1) begin
        pm = (ho_q >= 4'd2);
        if (ho_q >= 4'd3) begin
          hd_now = 4'd0;
          ho_now = ho_q - 4'd2;
        end
      end else begin
        pm = 1'b1;
        if (ho_q <= 4'd1) begin
          hd_now = 4'd0;
          ho_now = ho_q + 4'd8;
        end else begin
          hd_now = 4'd1;
          ho_now = ho_q - 4'd2;
        end
      end
    end
  end

  assign md_now   = md_q;
  assign mo_now   = mo_q;
  assign sd_now   = sd_q;
  assign so_now   = so_q;
  assign set_ack  = ack_q;
  assign set_err  = err_q;
  assign sec_tick = sec_tick_q;
  assign min_tick = min_tick_q;

endmodule
